// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO controller bundle: producer request, synced read pointer, and status/strobe back.
interface wptr_full_ctrl_if #(
    parameter int ADDRBITS = 4
);
    logic                w_en;
    logic [ADDRBITS:0]   r_syn;
    logic                ovf_clr;
    logic                w_push;
    logic [ADDRBITS-1:0] w_addr;
    logic [ADDRBITS:0]   wgrey;
    logic                w_full;
    logic                w_almost_full;
    logic [ADDRBITS:0]   w_level;
    logic                w_overflow;

    modport master (
        output w_en, r_syn, ovf_clr,
        input  w_push, w_addr, wgrey, w_full, w_almost_full, w_level, w_overflow
    );

    modport slave (
        input  w_en, r_syn, ovf_clr,
        output w_push, w_addr, wgrey, w_full, w_almost_full, w_level, w_overflow
    );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Async FIFO write-pointer controller: Gray pointer, full/almost-full, occupancy, sticky overflow.
// Latency: w_push/w_addr combinational with w_en; pointer and flags registered on the same edge.
// Backpressure: writes while w_full are dropped (w_push=0) and latch w_overflow until ovf_clr.
module wptr_full_ctrl #(
    parameter int ADDRBITS  = 4,
    parameter int AF_THRESH = 12
) (
    input  logic             w_clk,
    input  logic             reset,
    wptr_full_ctrl_if.slave  bus
);
    localparam int PW = ADDRBITS + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wgrey_q;
    logic          full_q;
    logic          af_q;
    logic [PW-1:0] level_q;
    logic          ovf_q;

    logic          push;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgrey_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          full_next;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign push       = bus.w_en & ~full_q;
    assign wbin_next  = wbin + {{ADDRBITS{1'b0}}, push};
    assign wgrey_next = (wbin_next >> 1) ^ wbin_next;
    assign rbin       = gray2bin(bus.r_syn);
    assign level_next = wbin_next - rbin;
    // Full when write is exactly one lap ahead: top two Gray bits differ, rest match.
    assign full_next  = (wgrey_next == {~bus.r_syn[PW-1:PW-2], bus.r_syn[PW-3:0]});

    always_ff @(posedge w_clk or negedge reset) begin
        if (!reset) begin
            wbin    <= '0;
            wgrey_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin    <= wbin_next;
            wgrey_q <= wgrey_next;
            full_q  <= full_next;
            af_q    <= (level_next >= AF_LVL);
            level_q <= level_next;
            if (bus.w_en & full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.w_push        = push;
    assign bus.w_addr        = wbin[ADDRBITS-1:0];
    assign bus.wgrey         = wgrey_q;
    assign bus.w_full        = full_q;
    assign bus.w_almost_full = af_q;
    assign bus.w_level       = level_q;
    assign bus.w_overflow    = ovf_q;
endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-side controller for the bridge's asynchronous FIFO. It owns the write pointer in the `w_clk` domain and generates the memory write strobe and address. It compares its Gray-coded write pointer against the read pointer that has already been brought into this domain by the two-flop synchronizer, and from that produces full, almost-full, occupancy and a sticky overflow flag. It sits between the UART receive path (the producer) and the FIFO storage array, and its `wgrey` output feeds the read-side synchronizer.

## Interface
- `ADDRBITS`, 4, FIFO address width; depth = 2^ADDRBITS (16); pointers are ADDRBITS+1 bits wide.
- `AF_THRESH`, 12, almost-full level; legal range 1..2^ADDRBITS.

- `w_clk` input 1: write-domain clock. Everything in this block is clocked on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `w_en` input 1: producer write request, sampled at each rising edge.
- `r_syn` input ADDRBITS+1: Gray-coded read pointer, already synchronized to `w_clk`.
- `ovf_clr` input 1: clears `w_overflow`.
- `w_push` output 1: memory write enable; `w_en & ~w_full` (combinational).
- `w_addr` output ADDRBITS: memory write address; the low ADDRBITS bits of the binary write pointer.
- `wgrey` output ADDRBITS+1: registered Gray write pointer, sent to the read-side synchronizer.
- `w_full` output 1: registered full flag.
- `w_almost_full` output 1: registered; asserted when `w_level >= AF_THRESH`.
- `w_level` output ADDRBITS+1: registered occupancy, range 0..2^ADDRBITS.
- `w_overflow` output 1: sticky; set when a write is attempted while full.

## Operation
- State registers: `wbin` and `wgrey` (both ADDRBITS+1 bits), plus `w_full`, `w_almost_full`, `w_level` and `w_overflow`.
- Next-pointer computation:
  - `wbin_next = wbin + w_push`, modulo 2^(ADDRBITS+1).
  - `wgrey_next = (wbin_next >> 1) ^ wbin_next`.
- Full detection: `full_next` is true when `wgrey_next` equals `r_syn` with its two MSBs inverted and its remaining bits equal.
- Occupancy:
  - `rbin = gray2bin(r_syn)`, computed as an XOR prefix from the MSB down.
  - `level_next = wbin_next - rbin`, modulo 2^(ADDRBITS+1).
  - `w_almost_full` is registered as `level_next >= AF_THRESH`.
- Each edge registers `wbin_next`, `wgrey_next`, `full_next`, `level_next` and the almost-full compare.
- Overflow:
  - `w_en & w_full` at an edge sets `w_overflow`.
  - `ovf_clr` clears it.
  - If set and clear occur together, set wins.
- A write while full is dropped: `w_push` stays 0 and the pointers hold.
- Wrap-around: `wbin` wraps from 2^(ADDRBITS+1)-1 to 0. Full and level stay correct through the wrap because the arithmetic is modulo.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous). Data in the memory is abandoned; the read side must also be reset.

## Timing
- Reset values:
  - `wbin`, `wgrey`, `w_addr`, `w_level`: 0.
  - `w_full`, `w_almost_full`, `w_overflow`: 0.
  - `w_push` follows `w_en` (because `w_full` = 0).
- Write latency:
  - `w_push` and `w_addr` are valid in the same cycle as `w_en`.
  - The memory captures the data at that rising edge.
  - `wgrey`, `w_level` and `w_full` reflect the write immediately after that edge.
- Full assertion: the write that makes the FIFO full raises `w_full` on that same edge, so a write in the next cycle is already blocked (zero-cycle lookahead).
- Full deassertion is pessimistic:
  - A read becomes visible on `r_syn` two `w_clk` edges after the read-side update.
  - `w_full` and `w_level` update on the first edge after `r_syn` changes.
- Simultaneous write and `r_syn` advance in one cycle: both are used together, so level is unchanged and full is recomputed from both.
- `wgrey` changes by exactly one bit per push, and never glitches because it is registered.

## Test plan
- Reset with `w_en`=0 → all registered outputs are 0; `w_addr`=0.
- 16 consecutive writes, `r_syn`=0:
  - `wgrey` sequence is 0,1,3,2,6,…
  - `w_almost_full` rises after the 12th edge (`w_level`=12).
  - `w_full` rises after the 16th edge (`w_level`=16, `wgrey`=5'b11000).
- 17th write while full → `w_push`=0, `wbin` unchanged, `w_overflow`=1. Then `ovf_clr` with `w_en`=0 → `w_overflow`=0.
- From full, set `r_syn`=5'b00001 (one read) → after 1 edge, `w_full`=0 and `w_level`=15. A write in that cycle → `w_full`=1 again.
- Perform 40 writes, each matched by a 1-step `r_syn` advance two cycles later → pointers wrap past 31 to 0, `w_level` never exceeds 2, `w_full` is never asserted.
- Hold `w_en`=1 and `ovf_clr`=1 together while full → `w_overflow` stays 1. Assert `reset` mid-stream → all outputs read 0 without waiting for a clock edge.
